// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex 7-segment scanner: double-buffered digit/mask/brightness, PWM brightness, per-digit dp/blank/blink.
// Outputs registered (1 clk after idx/phase state); no backpressure, load is sampled every cycle.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int SUB_DIV        = 12500,
    parameter int BRIGHT_BITS    = 3,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit EN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    load,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   seg_en,
    output logic [7:0]              seg_out0,
    output logic [7:0]              seg_out1
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SUB_W-1:0]       SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]       BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [BRIGHT_BITS-1:0] PH_LAST  = '1;
    localparam logic [7:0]             SEG_OFF  = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0]  EN_OFF   = {NUM_DIGITS{EN_ACTIVE_LOW}};

    logic [SUB_W-1:0]       sub_cnt;
    logic [BRIGHT_BITS-1:0] phase;
    logic [IDX_W-1:0]       idx;
    logic [BLK_W-1:0]       blink_cnt;
    logic                   blink_ph;
    logic                   pending;

    logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
    logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
    logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
    logic [NUM_DIGITS-1:0]   sh_blink, act_blink;
    logic [BRIGHT_BITS-1:0]  sh_bright, act_bright;

    logic sub_wrap;
    logic ph_wrap;
    logic boundary;

    assign sub_wrap = (sub_cnt == SUB_LAST);
    assign ph_wrap  = sub_wrap && (phase == PH_LAST);
    assign boundary = ph_wrap && (idx == IDX_LAST);

    // Returns {g,f,e,d,c,b,a}; 'b' and 'd' are the lowercase glyphs.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt   <= '0;
            phase     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
            if (sub_wrap) phase <= phase + 1'b1;
            if (ph_wrap)  idx   <= boundary ? '0 : idx + 1'b1;
            if (boundary) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // A load coinciding with the boundary lands in shadow after the copy, so it stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_blink   <= '0;
            sh_bright  <= '0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            act_blink  <= '0;
            act_bright <= '0;
        end else begin
            if (load) begin
                sh_digits <= digits;
                sh_dp     <= dp_mask;
                sh_blank  <= blank_mask;
                sh_blink  <= blink_mask;
                sh_bright <= brightness;
                pending   <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            if (boundary && pending) begin
                act_digits <= sh_digits;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_blink  <= sh_blink;
                act_bright <= sh_bright;
            end
        end
    end

    logic [4*NUM_DIGITS-1:0] digit_shift;
    logic [3:0]              cur_hex;
    logic                    lit;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   en_nxt;

    always_comb begin
        digit_shift = act_digits >> {idx, 2'b00};
        cur_hex     = digit_shift[3:0];
        lit         = !act_blank[idx] && !(act_blink[idx] && blink_ph) && (phase <= act_bright);
        en_nxt      = EN_OFF;
        seg_nxt     = SEG_OFF;
        if (lit) begin
            en_nxt  = (NUM_DIGITS'(1) << idx) ^ EN_OFF;
            seg_nxt = {act_dp[idx], hex7(cur_hex)} ^ SEG_OFF;
        end
    end

    // Enables switch in one register update, so two digits are never driven together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_en     <= EN_OFF;
            seg_out0   <= SEG_OFF;
            seg_out1   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg_en     <= en_nxt;
            seg_out0   <= seg_nxt;
            seg_out1   <= seg_nxt;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: 4 digits, 2 clk sub-slots, 4 phases, 2-frame blink; active-high and active-low instances.
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, rst_n_b, load;
    logic [15:0] digits;
    logic [3:0]  dp_mask, blank_mask, blink_mask;
    logic [1:0]  brightness;
    logic        frame_done_a, frame_done_b;
    logic [3:0]  seg_en_a, seg_en_b;
    logic [7:0]  seg_out0_a, seg_out1_a, seg_out0_b, seg_out1_b;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(4), .SUB_DIV(2), .BRIGHT_BITS(2), .BLINK_FRAMES(2),
                    .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .brightness(brightness), .load(load), .frame_done(frame_done_a),
        .seg_en(seg_en_a), .seg_out0(seg_out0_a), .seg_out1(seg_out1_a));

    seg_scan_ctrl #(.NUM_DIGITS(4), .SUB_DIV(2), .BRIGHT_BITS(2), .BLINK_FRAMES(2),
                    .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .brightness(brightness), .load(load), .frame_done(frame_done_b),
        .seg_en(seg_en_b), .seg_out0(seg_out0_b), .seg_out1(seg_out1_b));

    typedef struct {
        int          edge_no;
        logic [15:0] digits;
        logic [3:0]  dp, blank, blink;
        logic [1:0]  bright;
    } ld_t;

    typedef struct {
        logic [3:0] val;
        logic       dp;
        logic [7:0] exp;
    } vec_t;

    ld_t        loads[$];
    logic [7:0] seg7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    int   edges;
    int   passed;
    int   total;
    logic b_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    endtask

    // Expected outputs after n clock edges since reset release, from frame timing and load history:
    // slot = 8 clks, frame = 32 clks; a frame shows the newest load sampled before its first edge.
    function automatic void model(input int n, output logic [3:0] en, output logic [7:0] seg, output logic fd);
        int   s, idx, ph, f;
        ld_t  r;
        logic lit;
        en  = '0;
        seg = '0;
        fd  = 1'b0;
        if (n == 0) return;
        s   = n - 1;
        idx = (s / 8) % 4;
        ph  = (s % 8) / 2;
        f   = s / 32;
        fd  = (n % 32 == 0);
        r.edge_no = 0; r.digits = '0; r.dp = '0; r.blank = 4'hF; r.blink = '0; r.bright = '0;
        for (int i = loads.size() - 1; i >= 0; i--) begin
            if (loads[i].edge_no < 32 * f) begin
                r = loads[i];
                break;
            end
        end
        lit = !r.blank[idx] && !(r.blink[idx] && ((f / 2) % 2 == 1)) && (ph <= int'(r.bright));
        if (lit) begin
            en  = 4'(1 << idx);
            seg = seg7[r.digits[idx*4 +: 4]] | (r.dp[idx] ? 8'h80 : 8'h00);
        end
    endfunction

    task automatic step();
        logic [3:0] e, ne;
        logic [7:0] s, ns;
        logic       f;
        @(posedge clk);
        edges++;
        #1;
        model(edges, e, s, f);
        ne = ~e;
        ns = ~s;
        chk("seg_en", seg_en_a, e);
        chk("seg_out0", seg_out0_a, s);
        chk("seg_out1", seg_out1_a, s);
        chk("frame_done", frame_done_a, f);
        if (b_on) begin
            chk("seg_en_b", seg_en_b, ne);
            chk("seg_out0_b", seg_out0_b, ns);
            chk("seg_out1_b", seg_out1_b, ns);
            chk("frame_done_b", frame_done_b, f);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                           input logic [3:0] bk, input logic [1:0] br);
        ld_t r;
        digits = d; dp_mask = dp; blank_mask = bl; blink_mask = bk; brightness = br;
        load = 1'b1;
        r.edge_no = edges + 1; r.digits = d; r.dp = dp; r.blank = bl; r.blink = bk; r.bright = br;
        loads.push_back(r);
        step();
        load = 1'b0;
    endtask

    task automatic to_frame_end();
        while (edges % 32 != 0) step();
    endtask

    task automatic to_boundary_m1();
        while (edges % 32 != 31) step();
    endtask

    task automatic count_frame(input int exp_on);
        int cnt[4];
        to_frame_end();
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        repeat (32) begin
            step();
            for (int d = 0; d < 4; d++) if (seg_en_a[d]) cnt[d]++;
        end
        for (int d = 0; d < 4; d++) chk("en_clks_per_digit", cnt[d], exp_on);
    endtask

    task automatic reset_both();
        rst_n = 1'b0; rst_n_b = 1'b0;
        #1;
        chk("rst_en", seg_en_a, 4'h0);
        chk("rst_seg0", seg_out0_a, 8'h00);
        chk("rst_seg1", seg_out1_a, 8'h00);
        chk("rst_fd", frame_done_a, 1'b0);
        chk("rst_en_b", seg_en_b, 4'hF);
        chk("rst_seg0_b", seg_out0_b, 8'hFF);
        chk("rst_seg1_b", seg_out1_b, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n_b = 1'b1;
        edges = 0;
        loads.delete();
    endtask

    initial begin
        vec_t vecs[16];
        int   en_cnt, fd_cnt;
        vecs[0]  = '{4'h0, 1'b0, 8'h3F}; vecs[1]  = '{4'h1, 1'b1, 8'h86};
        vecs[2]  = '{4'h2, 1'b0, 8'h5B}; vecs[3]  = '{4'h3, 1'b1, 8'hCF};
        vecs[4]  = '{4'h4, 1'b0, 8'h66}; vecs[5]  = '{4'h5, 1'b1, 8'hED};
        vecs[6]  = '{4'h6, 1'b0, 8'h7D}; vecs[7]  = '{4'h7, 1'b1, 8'h87};
        vecs[8]  = '{4'h8, 1'b0, 8'h7F}; vecs[9]  = '{4'h9, 1'b1, 8'hEF};
        vecs[10] = '{4'hA, 1'b0, 8'h77}; vecs[11] = '{4'hB, 1'b1, 8'hFC};
        vecs[12] = '{4'hC, 1'b0, 8'h39}; vecs[13] = '{4'hD, 1'b1, 8'hDE};
        vecs[14] = '{4'hE, 1'b0, 8'h79}; vecs[15] = '{4'hF, 1'b1, 8'hF1};
        passed = 0; total = 0; edges = 0; b_on = 1'b1;
        load = 1'b0; digits = '0; dp_mask = '0; blank_mask = '0; blink_mask = '0; brightness = '0;
        rst_n = 1'b1; rst_n_b = 1'b1;
        @(posedge clk);
        #1;
        reset_both();

        // Dark until first load; frame_done every 32 clks.
        en_cnt = 0; fd_cnt = 0;
        repeat (40) begin
            step();
            if (seg_en_a != 4'h0) en_cnt++;
            if (frame_done_a) fd_cnt++;
        end
        chk("dark_en_cycles", en_cnt, 0);
        chk("fd_pulses_40", fd_cnt, 1);

        do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd3);
        count_frame(8);
        to_frame_end();
        repeat (4) step(); chk("dig0_seg", seg_out0_a, 8'h3F);
        repeat (8) step(); chk("dig1_seg", seg_out0_a, 8'h06);
        repeat (8) step(); chk("dig2_seg", seg_out0_a, 8'h5B);
        repeat (8) step(); chk("dig3_seg", seg_out1_a, 8'h4F);

        do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd0);
        count_frame(2);
        do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd1);
        count_frame(4);

        // Mid-frame load then a load on the boundary clock.
        do_load(16'h1111, 4'h0, 4'h0, 4'h0, 2'd3);
        to_frame_end();
        repeat (10) step();
        do_load(16'h5555, 4'h0, 4'h0, 4'h0, 2'd3);
        chk("mid_load_no_change", seg_out0_a, 8'h06);
        to_boundary_m1();
        do_load(16'h8888, 4'h0, 4'h0, 4'h0, 2'd3);
        chk("bnd_load_old_frame", seg_out0_a, 8'h06);
        repeat (4) step();
        chk("first_load_shown", seg_out0_a, 8'h6D);
        to_frame_end();
        repeat (4) step();
        chk("second_load_shown", seg_out0_a, 8'h7F);

        // Blink on digit 1 only.
        do_load(16'h3210, 4'h0, 4'h0, 4'b0010, 2'd3);
        to_frame_end();
        for (int k = 0; k < 8; k++) begin
            int   f;
            logic l0, l1;
            f = edges / 32; l0 = 1'b0; l1 = 1'b0;
            repeat (32) begin
                step();
                if (seg_en_a[0]) l0 = 1'b1;
                if (seg_en_a[1]) l1 = 1'b1;
            end
            chk("blink_d1", l1, ((f / 2) % 2 == 0));
            chk("blink_d0", l0, 1'b1);
        end

        for (int i = 0; i < 16; i++) begin
            logic [7:0] nexp;
            nexp = ~vecs[i].exp;
            do_load({4{vecs[i].val}}, {4{vecs[i].dp}}, 4'h0, 4'h0, 2'd3);
            to_frame_end();
            repeat (3) step();
            chk("decode", seg_out0_a, vecs[i].exp);
            chk("decode_b", seg_out0_b, nexp);
        end

        repeat (25) begin
            int gap;
            gap = $urandom_range(1, 40);
            repeat (gap) step();
            if ($urandom_range(0, 3) == 0) to_boundary_m1();
            do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
        end
        repeat (70) step();

        // Reset mid-frame with a pending load: shadow is discarded.
        do_load(16'h0000, 4'h0, 4'h0, 4'h0, 2'd3);
        to_frame_end();
        repeat (5) step();
        do_load(16'h7777, 4'h0, 4'h0, 4'h0, 2'd3);
        repeat (3) step();
        #3;
        rst_n = 1'b0; rst_n_b = 1'b0;
        #1;
        chk("async_rst_en", seg_en_a, 4'h0);
        chk("async_rst_seg", seg_out0_a, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n_b = 1'b1;
        edges = 0;
        loads.delete();
        en_cnt = 0;
        repeat (70) begin
            step();
            if (seg_en_a != 4'h0) en_cnt++;
        end
        chk("shadow_discarded", en_cnt, 0);

        do_load(16'h0000, 4'h0, 4'h0, 4'h0, 2'd3);
        to_frame_end();
        repeat (3) step();
        chk("b_zero_seg", seg_out0_b, 8'hC0);
        chk("b_zero_en", seg_en_b, 4'hE);
        b_on = 1'b0;
        @(posedge clk);
        #3;
        rst_n_b = 1'b0;
        #1;
        chk("b_async_en", seg_en_b, 4'hF);
        chk("b_async_seg0", seg_out0_b, 8'hFF);
        chk("b_async_seg1", seg_out1_b, 8'hFF);
        chk("b_async_fd", frame_done_b, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
